mem_port_arbiter: RTL and testbench

Shares one single-port memory bus between the fetch stage (instruction reads) and the MEM stage (data loads/stores) of the rv32IMA pipeline. A small FSM grants one requester at a time and registers its request onto the memory bus. It waits for the memory acknowledge, returns read data or a completion pulse, and exports per-requester stall signals to the pipeline. Data accesses have priority; a starvation counter guarantees forward progress for fetch; a timeout counter aborts hung transactions.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and the MEM
// stage. Data has priority, fetch is protected against starvation, hung accesses time out.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       starve_full;
  logic       idle;
  logic       last_wait;

  assign idle        = (state == IDLE);
  assign starve_full = (starve_cnt == 4'(STARVE_LIMIT));
  assign last_wait   = (wait_cnt == 8'(MAX_WAIT - 1));

  // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row.
  assign if_gnt_o = idle & if_req_i & (~d_req_i | starve_full);
  assign d_gnt_o  = idle & d_req_i & ~if_gnt_o;

  assign stall_if_o  = (if_req_i & ~if_gnt_o) | (state == IBUSY);
  assign stall_mem_o = (d_req_i & ~d_gnt_o) | (state == DBUSY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      err_o       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_gnt_o) begin
            state       <= IBUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            mem_be_o    <= 4'hF;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
          end else if (d_gnt_o) begin
            state       <= DBUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            mem_be_o    <= d_be_i;
            wait_cnt    <= '0;
            if (if_req_i && !starve_full)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        IBUSY, DBUSY: begin
          // An ack in the final wait cycle still completes normally.
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            if (state == IBUSY) begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= mem_rdata_i;
            end else begin
              d_rvalid_o <= 1'b1;
              d_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            end
          end else if (last_wait) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            if (state == IBUSY) begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= '0;
            end else begin
              d_rvalid_o <= 1'b1;
              d_rdata_o  <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single accesses and
// contention, plus hand sequences for reset, starvation, timeout and stalls.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic [3:0]  d_be_i = '0;
  logic        d_gnt_o, d_rvalid_o, err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_if_o, stall_mem_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, ack, rdata;
    logic [31:0] e_if_gnt, e_d_gnt, e_mem_req, e_mem_we, e_mem_addr, e_mem_be;
    logic [31:0] chk_wdata, e_mem_wdata;
    logic [31:0] e_if_rvalid, e_if_rdata, e_d_rvalid, e_d_rdata, e_err, e_stall_if, e_stall_mem;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    if_req_i    = v.if_req[0];
    if_addr_i   = v.if_addr;
    d_req_i     = v.d_req[0];
    d_we_i      = v.d_we[0];
    d_addr_i    = v.d_addr;
    d_wdata_i   = v.d_wdata;
    d_be_i      = v.d_be[3:0];
    mem_ack_i   = v.ack[0];
    mem_rdata_i = v.rdata;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; d_req_i = 0; d_we_i = 0; mem_ack_i = 0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0; mem_rdata_i = '0;
  endtask

  initial begin
    int winner[8];
    int n_arb;
    int hi;

    // inputs: if_req if_addr d_req d_we d_addr d_wdata d_be ack rdata
    // expect: if_gnt d_gnt mreq mwe maddr mbe chkw mwdata ifrv ifrd drv drd err sif smem
    vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093,
                 0, 0, 1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h100, 4'hF, 0, 0, 1, 32'h00500093, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0,
                 0, 1, 0, 0, 32'h100, 4'hF, 0, 0, 0, 32'h00500093, 0, 0, 0, 1, 0};
    vecs[4]  = '{1, 32'h104, 0, 0, 0, 0, 0, 1, 32'h12345678,
                 0, 0, 1, 1, 32'h2000, 4'b0011, 1, 32'hDEADBEEF, 0, 32'h00500093, 0, 0, 0, 1, 1};
    vecs[5]  = '{1, 32'h104, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 1, 32'h2000, 4'b0011, 1, 32'hDEADBEEF, 0, 32'h00500093, 1, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h00000013,
                 0, 0, 1, 0, 32'h104, 4'hF, 0, 0, 0, 32'h00500093, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h104, 4'hF, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 32'h3000, 32'h77777777, 4'b1100, 0, 0,
                 0, 1, 0, 0, 32'h104, 4'hF, 0, 0, 0, 32'h13, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,
                 0, 0, 1, 0, 32'h3000, 4'b1100, 0, 0, 0, 32'h13, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 32'h3000, 4'b1100, 0, 0, 0, 32'h13, 1, 32'hCAFEF00D, 0, 0, 0};

    // Reset state, then an asynchronous reset in the middle of a data access.
    idle_inputs();
    #3;
    check_output("rst_mem_req", 32'(mem_req_o), 0);
    check_output("rst_mem_addr", mem_addr_o, 0);
    check_output("rst_rvalids", {30'd0, if_rvalid_o, d_rvalid_o}, 0);
    check_output("rst_err", 32'(err_o), 0);
    @(negedge clk_i);
    rst_i = 1;
    step();
    d_req_i = 1; d_addr_i = 32'h40; d_be_i = 4'hF;
    #3;
    check_output("pre_rst_d_gnt", 32'(d_gnt_o), 1);
    step();
    d_req_i = 0;
    #1;
    check_output("pre_rst_mem_req", 32'(mem_req_o), 1);
    #1;
    rst_i = 0;
    #1;
    check_output("async_rst_mem_req", 32'(mem_req_o), 0);
    check_output("async_rst_stall_mem", 32'(stall_mem_o), 0);
    step();
    @(negedge clk_i);
    rst_i = 1;
    mem_ack_i = 1;
    step();
    mem_ack_i = 0;
    #3;
    check_output("post_rst_d_rvalid", 32'(d_rvalid_o), 0);
    check_output("post_rst_mem_addr", mem_addr_o, 0);
    check_output("post_rst_d_rdata", d_rdata_o, 0);
    step();

    // Table: single fetch, store/fetch contention, single load.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      #3;
      check_output($sformatf("v%0d_if_gnt", i), 32'(if_gnt_o), vecs[i].e_if_gnt);
      check_output($sformatf("v%0d_d_gnt", i), 32'(d_gnt_o), vecs[i].e_d_gnt);
      check_output($sformatf("v%0d_mem_req", i), 32'(mem_req_o), vecs[i].e_mem_req);
      check_output($sformatf("v%0d_mem_we", i), 32'(mem_we_o), vecs[i].e_mem_we);
      check_output($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].e_mem_addr);
      check_output($sformatf("v%0d_mem_be", i), 32'(mem_be_o), vecs[i].e_mem_be);
      if (vecs[i].chk_wdata[0])
        check_output($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].e_mem_wdata);
      check_output($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid_o), vecs[i].e_if_rvalid);
      check_output($sformatf("v%0d_if_rdata", i), if_rdata_o, vecs[i].e_if_rdata);
      check_output($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid_o), vecs[i].e_d_rvalid);
      check_output($sformatf("v%0d_d_rdata", i), d_rdata_o, vecs[i].e_d_rdata);
      check_output($sformatf("v%0d_err", i), 32'(err_o), vecs[i].e_err);
      check_output($sformatf("v%0d_stall_if", i), 32'(stall_if_o), vecs[i].e_stall_if);
      check_output($sformatf("v%0d_stall_mem", i), 32'(stall_mem_o), vecs[i].e_stall_mem);
      step();
    end

    // Starvation: both requesters held, zero-wait acks; fetch wins the 5th round.
    n_arb = 0;
    for (int c = 0; c < 12; c++) begin
      if_req_i = 1; if_addr_i = 32'h200;
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500 + 32'(c); d_be_i = 4'hF;
      mem_ack_i = 1; mem_rdata_i = 32'h55AA55AA;
      #3;
      if ((if_gnt_o || d_gnt_o) && n_arb < 8) begin
        winner[n_arb] = if_gnt_o ? 1 : 0;
        n_arb++;
      end
      step();
    end
    idle_inputs();
    check_output("starve_arb_count", 32'(n_arb), 6);
    for (int k = 0; k < 6; k++)
      if (k < n_arb)
        check_output($sformatf("starve_arb%0d_if_won", k), 32'(winner[k]), (k == 4) ? 1 : 0);
    step();

    // Timeout: load with no ack.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h600; d_be_i = 4'hF;
    #3;
    check_output("to_d_gnt", 32'(d_gnt_o), 1);
    step();
    d_req_i = 0;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (!mem_req_o) break;
      hi++;
      step();
    end
    check_output("to_req_cycles", 32'(hi), 15);
    check_output("to_d_rvalid", 32'(d_rvalid_o), 1);
    check_output("to_err", 32'(err_o), 1);
    check_output("to_d_rdata", d_rdata_o, 0);
    step();
    #3;
    check_output("to_err_cleared", 32'(err_o), 0);
    check_output("to_rvalid_cleared", 32'(d_rvalid_o), 0);
    step();

    // Ack in the last allowed wait cycle still completes normally.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h700; d_be_i = 4'hF;
    step();
    d_req_i = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        mem_ack_i = 1; mem_rdata_i = 32'h0BADCAFE;
        #3;
        check_output("late_ack_mem_req", 32'(mem_req_o), 1);
      end
      step();
      mem_ack_i = 0;
    end
    #3;
    check_output("late_ack_d_rvalid", 32'(d_rvalid_o), 1);
    check_output("late_ack_err", 32'(err_o), 0);
    check_output("late_ack_d_rdata", d_rdata_o, 32'h0BADCAFE);
    check_output("late_ack_mem_req_low", 32'(mem_req_o), 0);
    step();

    // Stalls: 3-wait-state load with a concurrent fetch waiting.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h800; d_be_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h108;
    #3;
    check_output("st_c0_d_gnt", 32'(d_gnt_o), 1);
    check_output("st_c0_stall_mem", 32'(stall_mem_o), 0);
    check_output("st_c0_stall_if", 32'(stall_if_o), 1);
    step();
    d_req_i = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ack_i = 1; mem_rdata_i = 32'h11112222;
      end
      #2;
      check_output($sformatf("st_c%0d_stall_mem", c), 32'(stall_mem_o), 1);
      check_output($sformatf("st_c%0d_stall_if", c), 32'(stall_if_o), 1);
      step();
    end
    mem_ack_i = 0;
    #3;
    check_output("st_c5_d_rvalid", 32'(d_rvalid_o), 1);
    check_output("st_c5_d_rdata", d_rdata_o, 32'h11112222);
    check_output("st_c5_stall_mem", 32'(stall_mem_o), 0);
    check_output("st_c5_if_gnt", 32'(if_gnt_o), 1);
    check_output("st_c5_stall_if", 32'(stall_if_o), 0);
    step();
    if_req_i = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h33334444;
    #3;
    check_output("st_c6_stall_if", 32'(stall_if_o), 1);
    check_output("st_c6_mem_addr", mem_addr_o, 32'h108);
    step();
    mem_ack_i = 0;
    #3;
    check_output("st_c7_if_rvalid", 32'(if_rvalid_o), 1);
    check_output("st_c7_if_rdata", if_rdata_o, 32'h33334444);
    check_output("st_c7_stall_if", 32'(stall_if_o), 0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
